// File: rtl/axi_log_pkg.sv
// -----------------------------------------------------------------------------
// axi_log_pkg
// Shared definitions for the AXI BRAM logger (writer) and the log reader.
// The packed BRAM entry layout lives here only once, so both sides agree on it:
//   [TS_LOW   +: TIMESTAMP_BITW] timestamp
//   [ADDR_LOW +: AXI_ADDR_BITW ] AXI address
//   [ID_LOW   +: AXI_ID_BITW   ] AXI ID
//   [LEN_LOW  +: AXI_LEN_BITW  ] AXI burst length
// Bits above LEN_LOW+AXI_LEN_BITW are unused by the reader.
// -----------------------------------------------------------------------------
package axi_log_pkg;

   localparam int AXI_ADDR_BITW     = 32;
   localparam int AXI_ID_BITW       = 8;
   localparam int AXI_LEN_BITW      = 8;
   localparam int TIMESTAMP_BITW    = 32;
   localparam int LOGGING_DATA_BITW = 96;
   localparam int NUM_SER_BRAMS     = 12;

   // Capacity in entries and the derived counter/index widths
   localparam int CAP      = 1024 * NUM_SER_BRAMS;
   localparam int CNT_BITW = $clog2(CAP + 1);
   localparam int IDX_BITW = $clog2(CAP);

   // Field offsets inside one BRAM word
   localparam int TS_LOW   = 0;
   localparam int ADDR_LOW = 32;
   localparam int ID_LOW   = 64;
   localparam int LEN_LOW  = ID_LOW + AXI_ID_BITW;

   typedef struct packed {
      logic [AXI_LEN_BITW-1:0]   len;
      logic [AXI_ID_BITW-1:0]    id;
      logic [AXI_ADDR_BITW-1:0]  addr;
      logic [TIMESTAMP_BITW-1:0] ts;
   } log_entry_t;

   localparam int ENTRY_BITW = $bits(log_entry_t);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/log_skid_buf.sv
// -----------------------------------------------------------------------------
// log_skid_buf
// Two-entry valid/ready buffer (output register plus skid register) carrying a
// log entry and its index. Entries leave in write order.
//   Clk_CI, Rst_RBI  clock, asynchronous active-low reset
//   Flush_SI         empties both registers on the next edge (wins over writes)
//   WrEn_SI          write WrEntry_DI / WrIdx_DI this cycle
//   RdValid_SO       output register holds an entry
//   RdReady_SI       consumer takes the output entry this cycle
//   RdEntry_DO       output entry (packed log_entry_t)
//   RdIdx_DO         output entry index
//   Count_DO         number of entries held (0..2)
// The writer must not write when both registers are full and no pop happens;
// the reader's credit logic guarantees this.
// -----------------------------------------------------------------------------
module log_skid_buf
   import axi_log_pkg::*;
(
   input  logic                  Clk_CI,
   input  logic                  Rst_RBI,
   input  logic                  Flush_SI,
   input  logic                  WrEn_SI,
   input  logic [ENTRY_BITW-1:0] WrEntry_DI,
   input  logic [IDX_BITW-1:0]   WrIdx_DI,
   output logic                  RdValid_SO,
   input  logic                  RdReady_SI,
   output logic [ENTRY_BITW-1:0] RdEntry_DO,
   output logic [IDX_BITW-1:0]   RdIdx_DO,
   output logic [1:0]            Count_DO
);

   localparam int WORD_BITW = ENTRY_BITW + IDX_BITW;

   logic                 out_valid_reg, out_valid_next;
   logic                 skid_valid_reg, skid_valid_next;
   logic [WORD_BITW-1:0] out_word_reg, out_word_next;
   logic [WORD_BITW-1:0] skid_word_reg, skid_word_next;
   logic [WORD_BITW-1:0] wr_word;
   logic                 pop;

   assign wr_word = {WrIdx_DI, WrEntry_DI};
   assign pop     = out_valid_reg & RdReady_SI;

   always_comb begin
      out_valid_next  = out_valid_reg;
      out_word_next   = out_word_reg;
      skid_valid_next = skid_valid_reg;
      skid_word_next  = skid_word_reg;
      if (Flush_SI) begin
         out_valid_next  = 1'b0;
         skid_valid_next = 1'b0;
      end else if (!out_valid_reg || pop) begin
         // Output register frees up: the older skid entry moves forward first
         if (skid_valid_reg) begin
            out_valid_next  = 1'b1;
            out_word_next   = skid_word_reg;
            skid_valid_next = WrEn_SI;
            skid_word_next  = wr_word;
         end else begin
            out_valid_next = WrEn_SI;
            out_word_next  = wr_word;
         end
      end else if (WrEn_SI) begin
         skid_valid_next = 1'b1;
         skid_word_next  = wr_word;
      end
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         out_valid_reg  <= 1'b0;
         skid_valid_reg <= 1'b0;
         out_word_reg   <= '0;
         skid_word_reg  <= '0;
      end else begin
         out_valid_reg  <= out_valid_next;
         skid_valid_reg <= skid_valid_next;
         out_word_reg   <= out_word_next;
         skid_word_reg  <= skid_word_next;
      end
   end

   assign RdValid_SO = out_valid_reg;
   assign RdEntry_DO = out_word_reg[ENTRY_BITW-1:0];
   assign RdIdx_DO   = out_word_reg[WORD_BITW-1:ENTRY_BITW];
   assign Count_DO   = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg};

endmodule

// File: rtl/axi_log_reader.sv
// -----------------------------------------------------------------------------
// axi_log_reader
// Drains entries 0..N-1 from the logging BRAM (read port only) and presents
// them, unpacked, on a valid/ready stream.
//   Clk_CI, Rst_RBI    clock, asynchronous active-low reset
//   Start_SI           start a drain of NumEntries_DI entries (IDLE only)
//   Abort_SI           stop a drain at once, drop buffered/in-flight entries
//   Busy_SO, Done_SO   busy level; one-cycle pulse after the last handshake
//   BramEn_SO/Addr_DO  BRAM read request (address = index << 2)
//   BramRd_DI          BRAM data, one cycle after the request
//   Entry*_SO/_DI/_DO  output stream: valid, ready, index and decoded fields
// Reads are issued only while buffered plus in-flight entries (after this
// cycle's pop) stay below two, so the 2-entry buffer can never overflow and a
// consumer with ready held high still sees one entry per cycle.
// -----------------------------------------------------------------------------
module axi_log_reader
   import axi_log_pkg::*;
(
   input  logic                         Clk_CI,
   input  logic                         Rst_RBI,
   input  logic                         Start_SI,
   input  logic                         Abort_SI,
   input  logic [CNT_BITW-1:0]          NumEntries_DI,
   output logic                         Busy_SO,
   output logic                         Done_SO,
   output logic                         BramEn_SO,
   output logic [IDX_BITW+1:0]          BramAddr_DO,
   input  logic [LOGGING_DATA_BITW-1:0] BramRd_DI,
   output logic                         EntryValid_SO,
   input  logic                         EntryReady_SI,
   output logic [IDX_BITW-1:0]          EntryIdx_DO,
   output logic [TIMESTAMP_BITW-1:0]    EntryTimestamp_DO,
   output logic [AXI_ADDR_BITW-1:0]     EntryAddr_DO,
   output logic [AXI_ID_BITW-1:0]       EntryId_DO,
   output logic [AXI_LEN_BITW-1:0]      EntryLen_DO
);

   localparam logic [CNT_BITW-1:0] CAP_CNT = CNT_BITW'(CAP);
   localparam logic [CNT_BITW-1:0] ONE_CNT = CNT_BITW'(1);

   state_t                state_reg, state_next;
   logic [CNT_BITW-1:0]   total_reg, total_next;
   logic [CNT_BITW-1:0]   rd_idx_reg, rd_idx_next;
   logic [CNT_BITW-1:0]   out_cnt_reg, out_cnt_next;
   logic                  pend_reg, pend_next;
   logic [IDX_BITW-1:0]   pend_idx_reg, pend_idx_next;

   logic [CNT_BITW-1:0]   clamped_num;
   logic                  bram_en;
   logic                  flush;
   logic                  done;
   logic                  pop;
   logic [2:0]            occ;
   logic                  wr_en;
   log_entry_t            rd_entry;
   log_entry_t            buf_entry;
   logic [ENTRY_BITW-1:0] buf_word;
   logic                  buf_valid;
   logic [1:0]            buf_cnt;
   logic [IDX_BITW-1:0]   buf_idx;
   logic                  unused_bram_bits;

   assign clamped_num = (NumEntries_DI > CAP_CNT) ? CAP_CNT : NumEntries_DI;
   assign pop         = buf_valid & EntryReady_SI;
   // Entries buffered plus the one returning this cycle, net of this cycle's pop
   assign occ         = {1'b0, buf_cnt} + {2'b00, pend_reg} - {2'b00, pop};

   always_comb begin
      state_next    = state_reg;
      total_next    = total_reg;
      rd_idx_next   = rd_idx_reg;
      out_cnt_next  = out_cnt_reg;
      bram_en       = 1'b0;
      flush         = 1'b0;
      done          = 1'b0;
      case (state_reg)
         IDLE: begin
            if (Start_SI) begin
               total_next   = clamped_num;
               rd_idx_next  = '0;
               out_cnt_next = '0;
               state_next   = (clamped_num == '0) ? DONE : READ;
            end
         end
         READ: begin
            if (Abort_SI) begin
               flush      = 1'b1;
               state_next = IDLE;
            end else begin
               if ((rd_idx_reg < total_reg) && (occ < 3'd2)) begin
                  bram_en     = 1'b1;
                  rd_idx_next = rd_idx_reg + ONE_CNT;
               end
               if (pop) begin
                  out_cnt_next = out_cnt_reg + ONE_CNT;
                  if (out_cnt_reg == total_reg - ONE_CNT) begin
                     state_next = DONE;
                  end
               end
            end
         end
         DONE: begin
            state_next = IDLE;
            if (Abort_SI) begin
               flush = 1'b1;
            end else begin
               done = 1'b1;
            end
         end
         default: begin
            flush      = 1'b1;
            state_next = IDLE;
         end
      endcase
      pend_next     = bram_en;
      pend_idx_next = rd_idx_reg[IDX_BITW-1:0];
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_reg    <= IDLE;
         total_reg    <= '0;
         rd_idx_reg   <= '0;
         out_cnt_reg  <= '0;
         pend_reg     <= 1'b0;
         pend_idx_reg <= '0;
      end else begin
         state_reg    <= state_next;
         total_reg    <= total_next;
         rd_idx_reg   <= rd_idx_next;
         out_cnt_reg  <= out_cnt_next;
         pend_reg     <= pend_next;
         pend_idx_reg <= pend_idx_next;
      end
   end

   // Unpack the returning BRAM word; an abort discards data still in flight
   assign rd_entry.ts      = BramRd_DI[TS_LOW +: TIMESTAMP_BITW];
   assign rd_entry.addr    = BramRd_DI[ADDR_LOW +: AXI_ADDR_BITW];
   assign rd_entry.id      = BramRd_DI[ID_LOW +: AXI_ID_BITW];
   assign rd_entry.len     = BramRd_DI[LEN_LOW +: AXI_LEN_BITW];
   assign unused_bram_bits = ^BramRd_DI[LOGGING_DATA_BITW-1:LEN_LOW+AXI_LEN_BITW];
   assign wr_en            = pend_reg & ~flush;

   log_skid_buf u_skid_buf (
      .Clk_CI     (Clk_CI),
      .Rst_RBI    (Rst_RBI),
      .Flush_SI   (flush),
      .WrEn_SI    (wr_en),
      .WrEntry_DI (rd_entry),
      .WrIdx_DI   (pend_idx_reg),
      .RdValid_SO (buf_valid),
      .RdReady_SI (EntryReady_SI),
      .RdEntry_DO (buf_word),
      .RdIdx_DO   (buf_idx),
      .Count_DO   (buf_cnt)
   );

   assign buf_entry = log_entry_t'(buf_word);

   assign Busy_SO           = (state_reg != IDLE);
   assign Done_SO           = done;
   assign BramEn_SO         = bram_en;
   assign BramAddr_DO       = bram_en ? {rd_idx_reg[IDX_BITW-1:0], 2'b00} : '0;
   assign EntryValid_SO     = buf_valid;
   assign EntryIdx_DO       = buf_idx;
   assign EntryTimestamp_DO = buf_entry.ts;
   assign EntryAddr_DO      = buf_entry.addr;
   assign EntryId_DO        = buf_entry.id;
   assign EntryLen_DO       = buf_entry.len;

endmodule

// File: tb/tb_axi_log_reader.sv
// -----------------------------------------------------------------------------
// tb_axi_log_reader
// Directed bench for axi_log_reader with a registered-read BRAM model.
// -----------------------------------------------------------------------------
module tb_axi_log_reader;
   import axi_log_pkg::*;

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic                         start;
   logic                         abort;
   logic [CNT_BITW-1:0]          num;
   logic                         busy;
   logic                         done;
   logic                         bram_en;
   logic [IDX_BITW+1:0]          bram_addr;
   logic [LOGGING_DATA_BITW-1:0] bram_rd = '0;
   logic                         valid;
   logic                         ready;
   logic [IDX_BITW-1:0]          idx;
   logic [TIMESTAMP_BITW-1:0]    ts_o;
   logic [AXI_ADDR_BITW-1:0]     addr_o;
   logic [AXI_ID_BITW-1:0]       id_o;
   logic [AXI_LEN_BITW-1:0]      len_o;
   logic [79:0]                  obs_f;

   logic [LOGGING_DATA_BITW-1:0] mem [0:CAP-1];

   int errors = 0;
   int checks = 0;
   int issued, accepted, last_addr, hs_cyc, first_valid_cyc;

   always #5 clk = ~clk;

   axi_log_reader dut (
      .Clk_CI            (clk),
      .Rst_RBI           (rst_n),
      .Start_SI          (start),
      .Abort_SI          (abort),
      .NumEntries_DI     (num),
      .Busy_SO           (busy),
      .Done_SO           (done),
      .BramEn_SO         (bram_en),
      .BramAddr_DO       (bram_addr),
      .BramRd_DI         (bram_rd),
      .EntryValid_SO     (valid),
      .EntryReady_SI     (ready),
      .EntryIdx_DO       (idx),
      .EntryTimestamp_DO (ts_o),
      .EntryAddr_DO      (addr_o),
      .EntryId_DO        (id_o),
      .EntryLen_DO       (len_o)
   );

   assign obs_f = {len_o, id_o, addr_o, ts_o};

   // BRAM read port: data one cycle after enable
   always @(posedge clk) begin
      if (bram_en) bram_rd <= mem[bram_addr[IDX_BITW+1:2]];
   end

   // Expected fields {len, id, addr, ts} of entry i
   function automatic logic [79:0] exp_f(input int i);
      logic [7:0] l;
      l = (i < 4) ? 8'd7 : 8'(i * 3);
      return {l, 8'(i), 32'hA000_0000 + 32'(4 * i), 32'h10 + 32'(i)};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(input int mode, input int cyc);
      if (mode == 0) return 1'b1;
      return ((cyc - 1) % 3) == 0;   // 1,0,0,1,0,0,...
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a drain of n entries and follows it to the Done pulse.
   task automatic drain(input int n, input int exp_n, input int rmode,
                        input bit poke, input bit abort_too, input int budget);
      logic [IDX_BITW-1:0] prev_idx;
      logic [79:0]         prev_f;
      bit                  prev_stall;
      bit                  done_seen;
      int                  cyc;
      issued = 0; accepted = 0; last_addr = -1; hs_cyc = -1; first_valid_cyc = -1;
      prev_stall = 0; done_seen = 0; prev_idx = '0; prev_f = '0;
      num = CNT_BITW'(n); start = 1'b1; abort = abort_too;
      tick();
      start = 1'b0; abort = 1'b0; cyc = 1;
      while (!done_seen && cyc <= budget) begin
         // Start while busy must be ignored
         start = poke && (cyc == 4);
         num   = (poke && (cyc == 4)) ? CNT_BITW'(1) : CNT_BITW'(n);
         ready = rdy(rmode, cyc);
         #1;
         if (prev_stall) check("hold_stable", {valid, idx, obs_f}, {1'b1, prev_idx, prev_f});
         if (bram_en) begin
            check("rd_addr", 128'(bram_addr), 128'(issued << 2));
            last_addr = int'(bram_addr);
            issued++;
         end
         if (valid && first_valid_cyc < 0) begin
            first_valid_cyc = cyc;
            check("first_valid_cycle", 128'(cyc), 128'(3));
         end
         if (valid && ready) begin
            check("entry_idx", 128'(idx), 128'(accepted));
            check("entry_fields", 128'(obs_f), 128'(exp_f(accepted)));
            accepted++;
            hs_cyc = cyc;
         end
         check("occupancy_le_2", 128'((issued - accepted) <= 2), 128'(1));
         if (done) begin
            done_seen = 1;
            check("done_count", 128'(accepted), 128'(exp_n));
            check("done_cycle", 128'(cyc), 128'((exp_n == 0) ? 1 : hs_cyc + 1));
         end
         prev_stall = valid && !ready;
         prev_idx   = idx;
         prev_f     = obs_f;
         start      = 1'b0;
         tick();
         cyc++;
      end
      check("done_seen", 128'(done_seen), 128'(1));
      #1;
      check("done_one_cycle", 128'(done), 128'(0));
      check("idle_after_done", 128'(busy), 128'(0));
      ready = 1'b0;
   endtask

   initial begin
      int acc;
      int stalls;
      for (int i = 0; i < CAP; i++) mem[i] = {16'hDEAD, exp_f(i)};
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; num = '0; ready = 1'b0;

      // Reset state
      #2;
      check("reset_outputs",
            {busy, done, bram_en, bram_addr, valid, idx, obs_f},
            '0);
      #20;
      tick();
      rst_n = 1'b1;
      tick();

      // Abort in IDLE has no effect
      abort = 1'b1;
      tick();
      check("abort_idle", {busy, valid, done}, 3'b000);
      abort = 1'b0;

      // N=4, ready high; Abort together with Start in IDLE: start wins
      drain(4, 4, 0, 1'b0, 1'b1, 100);
      check("n4_reads", 128'(issued), 128'(4));
      $display("txn N=4 accepted=%0d first_valid=%0d last_hs=%0d", accepted, first_valid_cyc, hs_cyc);

      // N=0: straight to DONE, no BRAM access, no entries
      drain(0, 0, 0, 1'b0, 1'b0, 20);
      check("n0_no_read", 128'(issued), 128'(0));
      check("n0_no_valid", 128'(first_valid_cyc), 128'(-1));
      $display("txn N=0 accepted=%0d reads=%0d", accepted, issued);

      // N=8, ready 1,0,0,... and a Start poke while busy
      drain(8, 8, 1, 1'b1, 1'b0, 100);
      check("n8_reads", 128'(issued), 128'(8));
      $display("txn N=8 stalled accepted=%0d reads=%0d", accepted, issued);

      // Oversized count (max of the 14-bit port) clamps to CAP
      drain(16383, CAP, 0, 1'b0, 1'b0, CAP + 20);
      check("clamp_reads", 128'(issued), 128'(CAP));
      check("clamp_last_addr", 128'(last_addr), 128'(16'hBFFC));
      $display("txn N=16383 accepted=%0d last_addr=%0h", accepted, last_addr);

      // Abort after 3 accepted entries with ready low
      num = CNT_BITW'(10); start = 1'b1;
      tick();
      start = 1'b0; acc = 0; stalls = 0;
      for (int c = 0; c < 40; c++) begin
         ready = (acc < 3);
         #1;
         if (valid && ready) acc++;
         else if (acc == 3) stalls++;
         if (stalls == 3) break;
         tick();
      end
      check("abort_pre_acc", 128'(acc), 128'(3));
      check("abort_pre_head", {valid, idx}, {1'b1, IDX_BITW'(3)});
      abort = 1'b1;
      #1;
      check("abort_no_done_now", 128'(done), 128'(0));
      tick();
      abort = 1'b0;
      #1;
      check("abort_next", {busy, valid, done, bram_en}, 4'b0000);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("abort_quiet", {busy, valid, done, bram_en}, 4'b0000);
      end
      $display("txn abort after %0d accepted", acc);
      drain(2, 2, 0, 1'b0, 1'b0, 40);
      $display("txn N=2 after abort accepted=%0d", accepted);

      // Asynchronous reset mid-drain
      num = CNT_BITW'(8); start = 1'b1; ready = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("midrun_valid", 128'(valid), 128'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            {busy, done, bram_en, bram_addr, valid, idx, obs_f},
            '0);
      ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("post_reset_idle", {busy, valid, bram_en}, 3'b000);
      drain(4, 4, 0, 1'b0, 1'b0, 40);
      $display("txn N=4 after reset accepted=%0d", accepted);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
